// File: rtl/out_stream_tx_if.sv
// rtl/out_stream_tx_if.sv - outbound result stream (valid/ready beat with last flag)
//
// Signals:
//   valid  beat valid, driven by the transmitter
//   data   beat payload, DW bits
//   last   final beat of a transfer
//   ready  downstream accept, driven by the receiver
interface out_stream_tx_if #(
    parameter int DW = 32
);
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
    logic          ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/out_stream_tx.sv
// rtl/out_stream_tx.sv - streams ds+1 words from one output-buffer bank onto the outbound stream
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   start_i    one-cycle pulse; begins a transfer when idle
//   bank_i     buffer bank to read, sampled with start_i
//   ds_i       last word address (word count - 1), sampled with start_i
//   busy_o     transfer in progress
//   done_o     one-cycle pulse after the last beat is accepted
//   rd_en_o    buffer read strobe
//   rd_bank_o  buffer bank for the read
//   rd_a_o     buffer read address
//   rd_d_i     buffer read data, valid the cycle after rd_en_o
//   m          outbound stream (master side)
module out_stream_tx #(
    parameter int DW    = 32,
    parameter int AW    = 12,
    parameter int DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                bank_i,
    input  logic [AW-1:0]       ds_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                rd_en_o,
    output logic                rd_bank_o,
    output logic [AW-1:0]       rd_a_o,
    input  logic [DW-1:0]       rd_d_i,
    out_stream_tx_if.master     m
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t          state_q;
    logic            bank_q;
    logic [AW-1:0]   ds_q;
    logic [AW-1:0]   addr_q;
    logic            done_q;

    // A read issued last cycle whose data lands in the queue this cycle.
    logic            inflight_q;
    logic            inflight_last_q;

    // Two-entry output queue; 1-bit pointers because the depth is fixed at 2.
    logic [DW-1:0]   q_data_q [2];
    logic            q_last_q [2];
    logic            head_q;
    logic            tail_q;
    logic [1:0]      count_q;
    logic [1:0]      count_d;

    logic            pop;
    logic            push;
    logic            issue;
    logic [2:0]      occ_after;

    assign pop  = (count_q != 2'd0) && m.ready;
    assign push = inflight_q;

    // Projected occupancy once the in-flight read lands and this cycle's pop
    // retires; issuing only below DEPTH guarantees the new read has a slot.
    assign occ_after = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == S_ISSUE) && (occ_after < 3'(DEPTH));

    assign count_d = count_q + {1'b0, push} - {1'b0, pop};

    assign rd_en_o   = issue;
    assign rd_bank_o = bank_q;
    assign rd_a_o    = addr_q;

    assign m.valid = (count_q != 2'd0);
    assign m.data  = q_data_q[head_q];
    assign m.last  = (count_q != 2'd0) && q_last_q[head_q];

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            bank_q          <= 1'b0;
            ds_q            <= '0;
            addr_q          <= '0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            head_q          <= 1'b0;
            tail_q          <= 1'b0;
            count_q         <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                q_data_q[i] <= '0;
                q_last_q[i] <= 1'b0;
            end
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= issue;
            inflight_last_q <= issue && (addr_q == ds_q);

            if (issue) begin
                addr_q <= addr_q + {{(AW-1){1'b0}}, 1'b1};
            end

            if (push) begin
                q_data_q[tail_q] <= rd_d_i;
                q_last_q[tail_q] <= inflight_last_q;
                tail_q           <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            count_q <= count_d;

            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        bank_q  <= bank_i;
                        ds_q    <= ds_i;
                        addr_q  <= '0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Equality stop so ds = 2^AW-1 ends without relying on wrap.
                    if (issue && (addr_q == ds_q)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && q_last_q[head_q]) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_stream_tx.sv
// tb/tb_out_stream_tx.sv - scoreboard bench for out_stream_tx
module tb_out_stream_tx;
    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          bank;
    logic [AW-1:0] ds;
    logic          busy, done, rd_en, rd_bank;
    logic [AW-1:0] rd_a;
    logic [DW-1:0] rd_d;

    out_stream_tx_if #(.DW(DW)) s_if ();

    out_stream_tx #(.DW(DW), .AW(AW), .DEPTH(2)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .bank_i    (bank),
        .ds_i      (ds),
        .busy_o    (busy),
        .done_o    (done),
        .rd_en_o   (rd_en),
        .rd_bank_o (rd_bank),
        .rd_a_o    (rd_a),
        .rd_d_i    (rd_d),
        .m         (s_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;
    beat_t exp_q[$];

    logic [31:0] salt;

    function automatic logic [DW-1:0] bufword(input logic b, input int a);
        return salt ^ (b ? 32'h5A5A_0000 : 32'h0000_0000) ^ (32'(a) * 32'h9E37_79B9) ^ 32'(a);
    endfunction

    int   start_cyc = 0, first_rd_cyc = -1, first_val_cyc = -1, last_beat_cyc = -1, done_cyc = -1;
    bit   xfer_active = 0, done_pending = 0, done_flag = 0;
    logic exp_bank = 1'b0;
    int   exp_ds = 0, rd_next = 0, rd_total = 0, hs_total = 0;
    int   ready_mode = 3;

    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    bit            pend = 0;
    logic          pend_bank = 1'b0;
    int            pend_a = 0;

    // Buffer model: 1-cycle read latency, garbage when no read was issued.
    always @(posedge clk) begin
        #1;
        if (pend) rd_d = bufword(pend_bank, pend_a);
        else      rd_d = $urandom;
    end

    // Downstream ready driver.
    always @(posedge clk) begin
        int k;
        #2;
        case (ready_mode)
            0: s_if.ready = 1'b1;
            1: begin
                k = cyc - start_cyc - 3;
                case (k)
                    1, 2, 4: s_if.ready = 1'b0;
                    default: s_if.ready = 1'b1;
                endcase
            end
            2: s_if.ready = ($urandom_range(0, 2) != 0);
            default: s_if.ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on every handshake and checks stream rules.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
            pend       = 0;
        end else begin
            if (done) begin
                chk("done_expected", done_pending, 1);
                chk("done_timing", cyc, last_beat_cyc + 1);
                chk("busy_at_done", busy, 0);
                chk("queue_empty_at_done", exp_q.size(), 0);
                done_pending = 0;
                xfer_active  = 0;
                done_flag    = 1;
                done_cyc     = cyc;
            end else begin
                chk("busy", busy, xfer_active && (cyc > start_cyc));
            end

            if (prev_stall) begin
                chk("valid_hold", s_if.valid, 1);
                chk("data_hold", s_if.data, prev_data);
                chk("last_hold", s_if.last, prev_last);
            end

            chk("occupancy", (rd_total - hs_total) <= 2, 1);

            pend      = rd_en;
            pend_bank = rd_bank;
            pend_a    = int'(rd_a);
            if (rd_en) begin
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                chk("rd_in_xfer", xfer_active, 1);
                chk("rd_bank", rd_bank, exp_bank);
                chk("rd_a", rd_a, rd_next[AW-1:0]);
                chk("rd_count", rd_next <= exp_ds, 1);
                rd_next++;
            end

            if (s_if.valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (s_if.valid && s_if.ready) begin
                chk("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", s_if.data, e.d);
                    chk("beat_last", s_if.last, e.l);
                    if (e.l) begin
                        done_pending  = 1;
                        last_beat_cyc = cyc;
                    end
                end
                hs_total++;
            end
            if (rd_en) rd_total++;

            prev_stall = s_if.valid && !s_if.ready;
            prev_data  = s_if.data;
            prev_last  = s_if.last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic b, input int d, input bit accept);
        start = 1'b1;
        bank  = b;
        ds    = d[AW-1:0];
        if (accept) begin
            start_cyc     = cyc;
            first_rd_cyc  = -1;
            first_val_cyc = -1;
            last_beat_cyc = -1;
            exp_bank      = b;
            exp_ds        = d;
            rd_next       = 0;
            rd_total      = 0;
            hs_total      = 0;
            done_flag     = 0;
            done_pending  = 0;
            xfer_active   = 1;
            for (int a = 0; a <= d; a++) begin
                beat_t e;
                e.d = bufword(b, a);
                e.l = (a == d);
                exp_q.push_back(e);
            end
        end
        tick();
        start = 1'b0;
        bank  = 1'($urandom);
        ds    = AW'($urandom);
    endtask

    // Returns in the done cycle (between negedge and next posedge).
    task automatic wait_done(input int budget, input bit timing);
        int n = 0;
        while (!done_flag && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("done_within_budget", done_flag, 1);
        if (done_flag && timing) begin
            chk("first_rd_cycle", first_rd_cyc, start_cyc + 1);
            chk("first_valid_cycle", first_val_cyc, start_cyc + 3);
            chk("last_beat_cycle", last_beat_cyc, start_cyc + 3 + exp_ds);
            chk("done_cycle", done_cyc, start_cyc + 4 + exp_ds);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bank  = 1'b0;
        ds    = '0;
        salt  = $urandom;
        ready_mode = 3;
        repeat (3) tick();

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_bank", rd_bank, 0);
        chk("rst_rd_a", rd_a, 0);
        chk("rst_m_valid", s_if.valid, 0);
        chk("rst_m_last", s_if.last, 0);
        chk("rst_m_data", s_if.data, 0);
        rst = 1'b0;
        tick();

        // ds=3, bank 0, no backpressure
        ready_mode = 0;
        tick();
        do_start(1'b0, 3, 1);
        wait_done(100, 1);

        // ds=7 with the 1,0,0,1,0,1,1,... ready pattern
        tick();
        ready_mode = 1;
        do_start(1'b1, 7, 1);
        wait_done(200, 0);

        // ds=0, bank 1
        tick();
        ready_mode = 0;
        do_start(1'b1, 0, 1);
        wait_done(50, 1);

        // ignored start at T+2, then a start in the done cycle
        tick();
        do_start(1'b0, 3, 1);
        tick();
        do_start(1'b1, 9, 0);
        wait_done(100, 1);
        do_start(1'b1, 5, 1);
        wait_done(100, 1);

        // reset mid-transfer with downstream stalled
        tick();
        ready_mode = 3;
        tick();
        do_start(1'b0, 15, 1);
        repeat (3) tick();
        rst = 1'b1;
        exp_q.delete();
        xfer_active  = 0;
        done_pending = 0;
        tick();
        rst = 1'b0;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_rd_en", rd_en, 0);
        chk("post_rst_rd_bank", rd_bank, 0);
        chk("post_rst_rd_a", rd_a, 0);
        chk("post_rst_m_valid", s_if.valid, 0);
        chk("post_rst_m_last", s_if.last, 0);
        chk("post_rst_m_data", s_if.data, 0);
        ready_mode = 0;
        repeat (20) tick();
        do_start(1'b0, 6, 1);
        wait_done(100, 1);

        // randomized transfers
        for (int it = 0; it < 8; it++) begin
            int   d;
            int   md;
            logic b;
            md = $urandom_range(0, 2);
            d  = $urandom_range(0, 40);
            b  = 1'($urandom);
            ready_mode = md;
            if ($urandom_range(0, 1) == 1) tick();
            do_start(b, d, 1);
            wait_done(40 * (d + 1) + 60, md == 0);
        end

        // full address range
        tick();
        ready_mode = 0;
        do_start(1'b1, 4095, 1);
        wait_done(5000, 1);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
